// File: rtl/tick_period_meter.sv
// Measures the clock-cycle spacing between tick_in strobes and reports it through a valid/ready register.
// Optional short-period rejection is compiled in with `define TICK_METER_GLITCH_EN.
module tick_period_meter #(
    parameter int CNT_W      = 26,
    parameter int MIN_PERIOD = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             clear,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             locked,
    output logic             overflow,
    output logic             missed,
    output logic             glitch
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] prev_period;
    logic             prev_valid;
    logic             accept;
    logic             saturate;
    logic             handshake;
`ifdef TICK_METER_GLITCH_EN
    logic             reject;
`endif

    assign period    = cnt + CNT_W'(1);
    assign handshake = period_valid && period_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        saturate   = 1'b0;
`ifdef TICK_METER_GLITCH_EN
        reject     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (tick_in) state_next = MEASURE;
            end
            MEASURE: begin
                // a period of 2^CNT_W cannot be represented, so a full counter aborts
                if (cnt == '1) begin
                    saturate   = 1'b1;
                    state_next = IDLE;
                end else if (tick_in) begin
`ifdef TICK_METER_GLITCH_EN
                    if (period < CNT_W'(MIN_PERIOD)) reject = 1'b1;
                    else                             accept = 1'b1;
`else
                    accept = 1'b1;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
        if (clear) state_next = IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            prev_period  <= '0;
            prev_valid   <= 1'b0;
            locked       <= 1'b0;
            overflow     <= 1'b0;
            missed       <= 1'b0;
        end else if (clear) begin
            cnt          <= '0;
            period_valid <= 1'b0;
            prev_valid   <= 1'b0;
            locked       <= 1'b0;
            overflow     <= 1'b0;
            missed       <= 1'b0;
        end else begin
            if (state == IDLE || accept || saturate) cnt <= '0;
            else                                     cnt <= period;

            if (saturate) begin
                overflow   <= 1'b1;
                locked     <= 1'b0;
                prev_valid <= 1'b0;
            end

            // a load in a handshake cycle replaces the consumed value, so valid stays high
            if (accept) begin
                period_out   <= period;
                period_valid <= 1'b1;
                prev_period  <= period;
                prev_valid   <= 1'b1;
                locked       <= prev_valid && (period == prev_period);
                if (period_valid && !period_ready) missed <= 1'b1;
            end else if (handshake) begin
                period_valid <= 1'b0;
            end
        end
    end

`ifdef TICK_METER_GLITCH_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      glitch <= 1'b0;
        else if (clear)  glitch <= 1'b0;
        else if (reject) glitch <= 1'b1;
    end
`else
    assign glitch = 1'b0;
`endif

endmodule

// File: tb/tb_tick_period_meter.sv
// Scoreboard bench for tick_period_meter: expected periods are queued as ticks are driven and
// compared when a result is consumed; flags are checked directly at fixed points.
module tb_tick_period_meter;

    localparam int CNT_W = 4;
    localparam int MIN_P = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             tick_in = 1'b0;
    logic             clear = 1'b0;
    logic             period_ready = 1'b1;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             locked;
    logic             overflow;
    logic             missed;
    logic             glitch;

    int checks = 0;
    int failures = 0;
    int exp_q[$];

    tick_period_meter #(.CNT_W(CNT_W), .MIN_PERIOD(MIN_P)) dut (
        .clock       (clock),
        .reset       (reset),
        .tick_in     (tick_in),
        .clear       (clear),
        .period_out  (period_out),
        .period_valid(period_valid),
        .period_ready(period_ready),
        .locked      (locked),
        .overflow    (overflow),
        .missed      (missed),
        .glitch      (glitch)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // consumed results are compared against the scoreboard
    always @(negedge clock) begin
        if (reset && period_valid && period_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", int'(period_out), -1);
            end else begin
                check("result", int'(period_out), exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse;
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
    endtask

    // closing tick N cycles after the previous one
    task automatic tick_after(input int n);
        step(n - 1);
        pulse();
    endtask

    task automatic do_clear;
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        check("rst_period_out", int'(period_out), 0);
        check("rst_valid", int'(period_valid), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_missed", int'(missed), 0);
        check("rst_glitch", int'(glitch), 0);
        reset = 1'b1;
        step(2);

        // single period of 5, valid for exactly one cycle
        pulse();
        exp_q.push_back(5);
        tick_after(5);
        check("t1_valid", int'(period_valid), 1);
        check("t1_out", int'(period_out), 5);
        check("t1_locked", int'(locked), 0);
        step();
        check("t1_valid_drop", int'(period_valid), 0);

        // regular ticks lock, an irregular one unlocks
        do_clear();
        pulse();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8);
            tick_after(8);
            check("t2_locked", int'(locked), (i == 0) ? 0 : 1);
        end
        exp_q.push_back(9);
        tick_after(9);
        check("t2_unlock", int'(locked), 0);

        // saturation with CNT_W=4
        do_clear();
        pulse();
        step(20);
        check("t3_overflow", int'(overflow), 1);
        check("t3_no_result", int'(period_valid), 0);
        pulse();
        exp_q.push_back(3);
        tick_after(3);
        check("t3_out", int'(period_out), 3);
        check("t3_overflow_sticky", int'(overflow), 1);
        step();
        do_clear();
        check("t3_overflow_clr", int'(overflow), 0);

        // overwrite without ready
        period_ready = 1'b0;
        pulse();
        tick_after(4);
        check("t4_missed_before", int'(missed), 0);
        tick_after(4);
        check("t4_out", int'(period_out), 4);
        check("t4_valid", int'(period_valid), 1);
        check("t4_missed", int'(missed), 1);
        do_clear();
        check("t4_missed_clr", int'(missed), 0);
        check("t4_valid_clr", int'(period_valid), 0);
        // load coinciding with a handshake
        pulse();
        tick_after(4);
        step(3);
        exp_q.push_back(4);
        period_ready = 1'b1;
        pulse();
        exp_q.push_back(4);
        check("t4_hs_valid", int'(period_valid), 1);
        check("t4_hs_missed", int'(missed), 0);
        step();
        check("t4_hs_drained", int'(period_valid), 0);

        // short period: rejected with the glitch filter, accepted without
        do_clear();
        pulse();
`ifdef TICK_METER_GLITCH_EN
        pulse();
        check("t5_glitch", int'(glitch), 1);
        check("t5_no_result", int'(period_valid), 0);
        exp_q.push_back(5);
        tick_after(4);
        check("t5_out", int'(period_out), 5);
`else
        exp_q.push_back(1);
        pulse();
        check("t5_out1", int'(period_out), 1);
        check("t5_glitch", int'(glitch), 0);
        exp_q.push_back(4);
        tick_after(4);
        check("t5_out4", int'(period_out), 4);
`endif
        step();

        // reset mid-measurement
        do_clear();
        pulse();
        step(3);
        reset = 1'b0;
        #1;
        check("t6_rst_out", int'(period_out), 0);
        check("t6_rst_valid", int'(period_valid), 0);
        check("t6_rst_flags", int'({locked, overflow, missed, glitch}), 0);
        step();
        reset = 1'b1;
        step(2);
        pulse();
        exp_q.push_back(6);
        tick_after(6);
        check("t6_out", int'(period_out), 6);
        step();

        // clear beats a tick: the next tick only re-arms
        tick_in = 1'b1;
        clear = 1'b1;
        step();
        tick_in = 1'b0;
        clear = 1'b0;
        tick_after(3);
        check("t6_clear_tick", int'(period_valid), 0);
        step(4);
        check("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_period_meter.md
# tick_period_meter

Measures the spacing, in `clock` cycles, between consecutive single-cycle `tick_in` strobes, such as the `clock_en` strobe from the clock divider, and reports each period through a valid/ready output register. It sits on the consuming side of the enable strobe. It is used to check the divider ratio on hardware and to flag missing, early or irregular ticks before they reach the FSMs.

## Interface
- `CNT_W`, default 26: width of the period counter and of `period_out`. A divide-by-2^25 tick gives period 33554432, which needs 26 bits.
- `MIN_PERIOD`, default 2: shortest legal period. Used only when `TICK_METER_GLITCH_EN` is defined.
- `clock`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: asynchronous, active-low reset.
- `tick_in`  in  1: strobe, synchronous to `clock`. Each high cycle is one tick.
- `clear`  in  1: synchronous soft clear.
- `period_out`  out  CNT_W: last measured period, in cycles.
- `period_valid`  out  1: `period_out` holds an unconsumed result.
- `period_ready`  in  1: consumer accepts the result when `period_valid && period_ready`.
- `locked`  out  1: the last two periods were equal.
- `overflow`  out  1: sticky; the counter saturated with no tick.
- `missed`  out  1: sticky; a result was overwritten before it was consumed.
- `glitch`  out  1: sticky; a short period was rejected. Tied to 0 without `TICK_METER_GLITCH_EN`.

## Operation
- FSM states:
  - IDLE: no reference tick yet.
  - MEASURE: counting from the last accepted tick.
- IDLE to MEASURE: on `tick_in`. `cnt` is set to 0.
- MEASURE:
  - `cnt` increments every cycle.
  - On `tick_in`, the period is `cnt+1`, so ticks at cycles t and t+N give N.
  - The period is loaded into the output register and `cnt` is set to 0. The FSM stays in MEASURE.
- Saturation:
  - If `cnt+1` would exceed 2^CNT_W−1, `overflow` is set.
  - The FSM goes to IDLE and no result is produced.
  - The next tick re-arms measurement.
- Output register:
  - A load sets `period_valid`.
  - On a handshake with no simultaneous load, `period_valid` clears.
  - Load while `period_valid && !period_ready`: the new value overwrites the old one and `missed` is set.
  - Load in the same cycle as a handshake: the old value is consumed, the new value is loaded, `period_valid` stays 1 and `missed` is unchanged.
- `locked`:
  - Set when a new period equals the previous accepted period.
  - Cleared when a new period differs, and on overflow.
  - The first period after IDLE never sets `locked`; it only primes the previous-period register.
- `clear`:
  - Returns the FSM to IDLE.
  - Zeroes `cnt`, `period_valid`, `locked` and all sticky flags.
  - `period_out` holds its value.
  - `clear` has priority over a `tick_in` or handshake in the same cycle.

## Timing
- Reset values: FSM IDLE, `cnt`=0, `period_out`=0, `period_valid`=0, `locked`=0, `overflow`=0, `missed`=0, `glitch`=0.
- Latency: `period_valid` and `period_out` update on the edge after the cycle in which the closing tick is high, so they are visible the following cycle.
- `locked`, `overflow`, `missed` and `glitch` update on the same edge as the event that causes them.
- Back-to-back ticks (tick high on consecutive cycles) are legal and give period 1.
- A `tick_in` held high for k cycles counts as k ticks.
- Asserting `reset` mid-measurement discards the count immediately. After reset is released, measurement restarts from the next tick.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `TICK_METER_GLITCH_EN` defined:
  - A closing tick with period < `MIN_PERIOD` is ignored as a tick: no load and no reset of `cnt`. The measurement continues from the original reference tick.
  - `glitch` is set.
- `TICK_METER_GLITCH_EN` undefined:
  - Every tick is accepted; `MIN_PERIOD` is unused.
  - `glitch` is constant 0.

## Test plan
- Ticks at cycles 10 and 15, `period_ready`=1 -> `period_out`=5 and `period_valid`=1 for exactly one cycle, at cycle 16. `locked`=0.
- Ticks every 8 cycles, four times, `period_ready`=1 -> three results of 8. `locked` rises with the second result and stays 1. A fifth tick after 9 cycles -> result 9, `locked`=0.
- `CNT_W`=4, tick then silence -> `overflow` set when `cnt` saturates, FSM in IDLE. Next two ticks 3 cycles apart -> result 3, `overflow` still 1 until `clear`.
- Ticks every 4 cycles with `period_ready`=0 -> second result overwrites the first (`period_out`=4) and `missed`=1. With `period_ready`=1 in the load cycle -> `period_valid` stays 1 and `missed` stays 0.
- `TICK_METER_GLITCH_EN`, `MIN_PERIOD`=3, ticks at cycles 0, 1 and 5 -> no result for the tick at cycle 1, `glitch`=1, result 5 after the tick at cycle 5. Without the macro -> results 1 and 4.
- `reset` low at cycle 3 of a measurement, high again, then ticks 6 cycles apart -> all outputs 0 during reset; a single result of 6 afterwards. `clear` together with a tick -> IDLE with no result.
